// File: rtl/ex_wb_buffer.sv
// EX->WB pipeline register: two-entry skid buffer with branch resolve and PC redirect.
// Latency: 1 cycle from accepted EX beat to out_valid (and to redirect pulse).
// Backpressure: in_ready is registered and drops only when both entries are occupied.
module ex_wb_buffer #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_ctrl,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_rt,
  input  logic [DATA_W-1:0] in_target,
  input  logic              in_zero,
  input  logic              in_neg,
  input  logic [REG_W-1:0]  in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_ctrl,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_rt,
  output logic [REG_W-1:0]  out_rd,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, next_state;

  logic              push;
  logic              pop;
  logic              taken;
  logic [3:0]        skid_ctrl;
  logic [DATA_W-1:0] skid_result;
  logic [DATA_W-1:0] skid_rt;
  logic [REG_W-1:0]  skid_rd;

  // Flush kills both sides of the handshake so neither EX nor WB sees a transfer.
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign out_valid = (state != EMPTY);

  // in_ctrl[2] = branch, [1] = btype (1: branch on negative, 0: on zero), [0] = jump.
  assign taken = in_ctrl[0] | (in_ctrl[2] & (in_ctrl[1] ? in_neg : in_zero));

  // Next-state decode of the occupancy FSM; flush always empties.
  always_comb begin
    next_state = state;
    case (state)
      EMPTY: if (push) next_state = ONE;
      ONE: begin
        if (push && !pop)      next_state = FULL;
        else if (pop && !push) next_state = EMPTY;
      end
      FULL: if (pop) next_state = ONE;
      default: next_state = EMPTY;
    endcase
    if (flush) next_state = EMPTY;
  end

  // State register plus registered ready derived from the upcoming occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != FULL);
    end
  end

  // Head/skid datapath: head always holds the oldest entry, skid the second.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ctrl    <= '0;
      out_result  <= '0;
      out_rt      <= '0;
      out_rd      <= '0;
      skid_ctrl   <= '0;
      skid_result <= '0;
      skid_rt     <= '0;
      skid_rd     <= '0;
    end else begin
      case (state)
        EMPTY, ONE: begin
          // In ONE a simultaneous pop frees the head, so the new beat replaces it.
          if (push && (state == EMPTY || pop)) begin
            out_ctrl   <= in_ctrl[6:3];
            out_result <= in_result;
            out_rt     <= in_rt;
            out_rd     <= in_rd;
          end else if (push) begin
            skid_ctrl   <= in_ctrl[6:3];
            skid_result <= in_result;
            skid_rt     <= in_rt;
            skid_rd     <= in_rd;
          end
        end
        FULL: begin
          if (pop) begin
            out_ctrl   <= skid_ctrl;
            out_result <= skid_result;
            out_rt     <= skid_rt;
            out_rd     <= skid_rd;
          end
        end
        default: ;
      endcase
    end
  end

  // One-cycle redirect pulse per accepted taken branch/jump; target held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= push & taken;
      if (push && taken) redirect_pc <= in_target;
    end
  end

endmodule

// File: tb/tb_ex_wb_buffer.sv
// Bench for ex_wb_buffer: scenario tasks plus a negedge scoreboard monitor.
// Inputs change 1 time unit after posedge; outputs are compared at negedge or posedge+1.
// The scoreboard queue tracks accepted beats and expected redirect pulses.
module tb_ex_wb_buffer;

  localparam int DATA_W = 32;
  localparam int REG_W  = 6;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_ctrl;
  logic [DATA_W-1:0] in_result;
  logic [DATA_W-1:0] in_rt;
  logic [DATA_W-1:0] in_target;
  logic              in_zero;
  logic              in_neg;
  logic [REG_W-1:0]  in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_ctrl;
  logic [DATA_W-1:0] out_result;
  logic [DATA_W-1:0] out_rt;
  logic [REG_W-1:0]  out_rd;
  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;

  typedef struct packed {
    logic [3:0]        ctrl;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] rt;
    logic [REG_W-1:0]  rd;
  } ent_t;

  ent_t              q[$];
  logic              exp_rv;
  logic [DATA_W-1:0] exp_pc;
  bit                mon_en;
  int                checks;
  int                errors;

  ex_wb_buffer #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_result(in_result), .in_rt(in_rt), .in_target(in_target),
    .in_zero(in_zero), .in_neg(in_neg), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_result(out_result), .out_rt(out_rt), .out_rd(out_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: check DUT against the queue model, then advance the model
  // with the transfers that the coming posedge will perform.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (redirect_valid !== exp_rv) begin
        errors++;
        $display("FAIL sb_redirect_valid t=%0t got %b want %b", $time, redirect_valid, exp_rv);
      end
      checks++;
      if (redirect_pc !== exp_pc) begin
        errors++;
        $display("FAIL sb_redirect_pc t=%0t got %h want %h", $time, redirect_pc, exp_pc);
      end
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL sb_out_valid t=%0t got %b want %b", $time, out_valid, q.size() != 0);
      end
      checks++;
      if (in_ready !== (q.size() < 2)) begin
        errors++;
        $display("FAIL sb_in_ready t=%0t got %b want %b", $time, in_ready, q.size() < 2);
      end
      if (out_valid === 1'b1 && q.size() != 0) begin
        checks++;
        if ({out_ctrl, out_result, out_rt, out_rd} !== q[0]) begin
          errors++;
          $display("FAIL sb_head t=%0t got %h/%h/%h/%h want %h/%h/%h/%h", $time,
                   out_ctrl, out_result, out_rt, out_rd,
                   q[0].ctrl, q[0].result, q[0].rt, q[0].rd);
        end
      end
    end
    if (rst) begin
      q.delete();
      exp_rv = 1'b0;
      exp_pc = '0;
      mon_en = 1'b1;
    end else if (flush) begin
      q.delete();
      exp_rv = 1'b0;
    end else begin
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      exp_rv = 1'b0;
      if (in_valid && in_ready) begin
        q.push_back({in_ctrl[6:3], in_result, in_rt, in_rd});
        if (in_ctrl[0] | (in_ctrl[2] & (in_ctrl[1] ? in_neg : in_zero))) begin
          exp_rv = 1'b1;
          exp_pc = in_target;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [6:0] ctrl, input logic [DATA_W-1:0] result,
                            input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] target,
                            input logic zero, input logic neg);
    in_valid  = 1'b1;
    in_ctrl   = ctrl;
    in_result = result;
    in_rt     = result ^ 32'hA5A5_0000;
    in_rd     = rd;
    in_target = target;
    in_zero   = zero;
    in_neg    = neg;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_beat(7'b1000001, 32'h55, 6'd9, 32'hF0, 1'b0, 1'b0);
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid, redirect_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags got rdy/vld/rv=%b%b%b want 100", in_ready, out_valid, redirect_valid);
    end
    checks++;
    if ({out_ctrl, out_result, out_rt, out_rd, redirect_pc} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h %h want all zero",
               out_ctrl, out_result, out_rt, out_rd, redirect_pc);
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive_beat(7'b1000000, 32'h1234, 6'd5, 32'h0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_ctrl, out_result, out_rd} !== {1'b1, 4'b1000, 32'h1234, 6'd5}) begin
      errors++;
      $display("FAIL single_out got vld=%b ctrl=%b res=%h rd=%0d want 1 1000 1234 5",
               out_valid, out_ctrl, out_result, out_rd);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_skid();
    logic [DATA_W-1:0] got[$];
    out_ready = 1'b0;
    drive_beat(7'b1100000, 32'h1, 6'd1, 32'h0, 1'b0, 1'b0);
    tick();
    drive_beat(7'b1010000, 32'h2, 6'd2, 32'h0, 1'b0, 1'b0);
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL skid_full_ready got %b want 0", in_ready);
    end
    drive_beat(7'b0001000, 32'h3, 6'd3, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (out_result !== 32'h1) begin
      errors++;
      $display("FAIL skid_hold_head got %h want 1", out_result);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      automatic logic acc = in_valid & in_ready;
      if (out_valid) got.push_back(out_result);
      tick();
      if (acc) in_valid = 1'b0;
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL skid_count got %0d beats want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== DATA_W'(i + 1)) begin
          errors++;
          $display("FAIL skid_order idx %0d got %h want %h", i, got[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_branch();
    out_ready = 1'b1;
    drive_beat(7'b0000100, 32'h10, 6'd0, 32'h40, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h40}) begin
      errors++;
      $display("FAIL beq_taken got %b %h want 1 40", redirect_valid, redirect_pc);
    end
    tick();
    checks++;
    if ({redirect_valid, redirect_pc} !== {1'b0, 32'h40}) begin
      errors++;
      $display("FAIL beq_pulse_end got %b %h want 0 40", redirect_valid, redirect_pc);
    end
    drive_beat(7'b0000110, 32'h11, 6'd0, 32'h60, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({redirect_valid, redirect_pc} !== {1'b0, 32'h40}) begin
      errors++;
      $display("FAIL bneg_not_taken got %b %h want 0 40", redirect_valid, redirect_pc);
    end
    drive_beat(7'b0000001, 32'h12, 6'd0, 32'h80, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h80}) begin
      errors++;
      $display("FAIL jump_taken got %b %h want 1 80", redirect_valid, redirect_pc);
    end
    tick();
    checks++;
    if (redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL jump_pulse_end got %b want 0", redirect_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_beat(7'b1000000, 32'hA, 6'd10, 32'h0, 1'b0, 1'b0);
    tick();
    drive_beat(7'b1000000, 32'hB, 6'd11, 32'h0, 1'b0, 1'b0);
    tick();
    flush = 1'b1;
    drive_beat(7'b1000001, 32'hC, 6'd12, 32'hC0, 1'b0, 1'b0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, redirect_valid} !== 3'b010) begin
      errors++;
      $display("FAIL flush_state got vld/rdy/rv=%b%b%b want 010", out_valid, in_ready, redirect_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_ghost cycle %0d got out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive_beat(7'b1000000, 32'h100, 6'd0, 32'h0, 1'b0, 1'b0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      drive_beat(7'b1000000, 32'h100 + i, 6'(i), 32'h0, 1'b0, 1'b0);
      tick();
      checks++;
      if ({out_valid, in_ready, out_result} !== {2'b11, 32'h100 + i}) begin
        errors++;
        $display("FAIL b2b beat %0d got vld=%b rdy=%b res=%h want 1 1 %h",
                 i, out_valid, in_ready, out_result, 32'h100 + i);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    drive_beat(7'b1000000, 32'hD1, 6'd1, 32'h0, 1'b0, 1'b0);
    tick();
    drive_beat(7'b1000000, 32'hD2, 6'd2, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive_beat(7'b1000001, 32'hD3, 6'd3, 32'hE0, 1'b0, 1'b0);
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid, redirect_valid} !== 3'b100) begin
      errors++;
      $display("FAIL rstfull_flags got rdy/vld/rv=%b%b%b want 100", in_ready, out_valid, redirect_valid);
    end
    checks++;
    if ({out_ctrl, out_result, out_rt, out_rd, redirect_pc} !== '0) begin
      errors++;
      $display("FAIL rstfull_data got %h %h %h %h %h want all zero",
               out_ctrl, out_result, out_rt, out_rd, redirect_pc);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mon_en    = 1'b0;
    exp_rv    = 1'b0;
    exp_pc    = '0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_result = '0;
    in_rt     = '0;
    in_target = '0;
    in_zero   = 1'b0;
    in_neg    = 1'b0;
    in_rd     = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_skid();
    test_branch();
    test_flush();
    test_back_to_back();
    test_reset_full();
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
